count_monitor: RTL
==================

# count_monitor

Downstream observer for the 4-bit loadable up-counter. It samples the counter's `count` output every clock and classifies each step as an increment, a wrap (15→0), a hold, or a jump (load/preset discontinuity). It keeps a saturating wrap tally and raises a level interrupt after a programmed number of wraps, or immediately on an unexpected jump. It sits between the counter and the system interrupt/status logic.

## Interface
- `ALARM_WRAPS`, default 4: wraps since arming that trigger ALARM; legal range 1..15.
- `WRAP_W`, default 8: width of the total wrap tally.

- `clk`  in  1: single system clock, rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: monitor enable.
- `count`  in  4: counter output, synchronous to `clk`.
- `cmp_val`  in  4: compare value for `match`.
- `irq_ack`  in  1: one-cycle acknowledge; clears `irq`.
- `wrap_cnt`  out  WRAP_W: total wraps seen; saturates at all-ones.
- `match`  out  1: one-cycle pulse when `count` becomes equal to `cmp_val`.
- `jump`  out  1: one-cycle pulse on a discontinuity.
- `irq`  out  1: level interrupt, high in ALARM or FAULT.
- `state`  out  2: FSM state. IDLE=0, ARMED=1, ALARM=2, FAULT=3.

## Operation
- Internal registers:
  - `prev_count[3:0]`.
  - `prev_valid`.
  - `win_wraps[3:0]`: wraps since last arm/ack.
- `prev_valid` behaviour:
  - Cleared by reset and whenever `en`=0.
  - Set on the first cycle with `en`=1.
- `prev_count` loads `count` every cycle that `en`=1.
- Classification runs only when `en`=1 and `prev_valid`=1. Let exp = (prev_count+1) mod 16:
  - count==exp and prev_count==15 → wrap event.
  - count==exp, otherwise → increment, no event.
  - count==prev_count → hold, no event.
  - anything else → jump event; `jump` pulses.
  - Exactly one class per cycle.
- `match` pulses when `en`=1, count==cmp_val, and NOT (prev_valid and prev_count==cmp_val). Holding at `cmp_val` gives a single pulse.
- Wrap event effects:
  - `wrap_cnt` += 1 unless already all-ones.
  - `win_wraps` += 1 only in ARMED.
- FSM transitions:
  - Any state, `en`=0 → IDLE. Clears `win_wraps`. `wrap_cnt` is retained. `en` has priority over everything except `rst`.
  - IDLE, `en`=1 → ARMED. `win_wraps`=0.
  - ARMED, jump event → FAULT. Jump takes precedence over a same-cycle ALARM condition.
  - ARMED, wrap event making `win_wraps`==ALARM_WRAPS → ALARM.
  - ALARM/FAULT, `irq_ack`=1 → ARMED. `win_wraps` is cleared to 0, or set to 1 if a wrap event occurs in the same cycle.
  - ALARM/FAULT: further wraps still count in `wrap_cnt`. Jumps still pulse `jump`. State is unchanged.
- `irq` = (state==ALARM or state==FAULT). It is a registered decode, not combinational from inputs.
- Arithmetic: all 4-bit compares are modulo 16. `wrap_cnt` never rolls over.
- Reset values: `wrap_cnt`=0, `match`=0, `jump`=0, `irq`=0, `state`=IDLE. `prev_count`=0, `prev_valid`=0, `win_wraps`=0.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Latency: `count` sampled at edge N is classified on that edge. The `match`/`jump` pulse, `wrap_cnt` update, and state change are visible from edge N until edge N+1.
- `match` and `jump` are exactly one cycle wide per event.
- `irq` rises in the same cycle `state` enters ALARM/FAULT. It falls on the edge that samples `irq_ack`=1.
- `irq_ack` while state is IDLE or ARMED: ignored.
- First enabled cycle after `en` rises: never reports wrap or jump. `match` may fire.
- `rst` asserted mid-operation: all registers clear immediately (asynchronous). The first post-reset enabled cycle is treated as a first sample.
- Counter reset to 0 while the monitor is running and `prev_count`≠15 and ≠0: classified as a jump.

## Test plan
- Free-run: reset, `en`=1, count 0→15→0→…, ALARM_WRAPS=4 → `wrap_cnt`=4 and state=ALARM with `irq`=1 on the cycle count returns to 0 for the 4th time. No `jump` pulses.
- Load discontinuity: in ARMED, count sequence 5,6,11 → `jump` pulses once on the sample of 11. State=FAULT, `irq`=1, `wrap_cnt` unchanged.
- Match/hold: `cmp_val`=9, count 8,9,9,9,10 → exactly one `match` pulse, on the first 9. Holds produce no `jump`.
- Ack with simultaneous wrap: in ALARM, assert `irq_ack` on the cycle of a 15→0 step → state=ARMED, `irq`=0, `win_wraps`=1, `wrap_cnt` incremented.
- Saturation: WRAP_W=2, drive 5 wraps → `wrap_cnt` stays 3 after the 3rd wrap.
- Async reset mid-ALARM: pulse `rst` between clock edges → `irq`, `state`, and `wrap_cnt` are 0 immediately. After release, the first enabled sample produces no `jump`.

Source files
------------

// File: rtl/count_monitor.sv
// count_monitor
// Observes a 4-bit up-counter every clock and classifies each step as an
// increment, a wrap (15->0), a hold or a jump (load/preset discontinuity).
// It keeps a saturating tally of all wraps and raises a level interrupt
// either after ALARM_WRAPS wraps since arming, or at once on a jump.
//
// Ports
//   i_clk       system clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_en        monitor enable; low forces IDLE and forgets the last sample
//   i_count     counter value being observed
//   i_cmp_val   compare value for o_match
//   i_irq_ack   one-cycle acknowledge, returns ALARM/FAULT to ARMED
//   o_wrap_cnt  total wraps seen, saturates at all-ones
//   o_match     one-cycle pulse when i_count becomes equal to i_cmp_val
//   o_jump      one-cycle pulse on a discontinuity
//   o_irq       level interrupt, high in ALARM or FAULT
//   o_state     FSM state
//
// state | meaning
// IDLE  | monitor disabled, no history
// ARMED | counting wraps toward ALARM_WRAPS, watching for jumps
// ALARM | ALARM_WRAPS wraps seen since arming, irq high until ack
// FAULT | unexpected jump seen while armed, irq high until ack

module count_monitor #(
    parameter int ALARM_WRAPS = 4,
    parameter int WRAP_W      = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [3:0]        i_count,
    input  logic [3:0]        i_cmp_val,
    input  logic              i_irq_ack,
    output logic [WRAP_W-1:0] o_wrap_cnt,
    output logic              o_match,
    output logic              o_jump,
    output logic              o_irq,
    output logic [1:0]        o_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_ALARM = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [3:0] ALARM_LVL = 4'(ALARM_WRAPS);

    logic [3:0]        r_prev_count;
    logic              r_prev_valid;
    logic [3:0]        r_win_wraps;
    logic [1:0]        r_state;
    logic [WRAP_W-1:0] r_wrap_cnt;
    logic              r_match;
    logic              r_jump;
    logic              r_irq;

    logic [3:0] w_exp;
    logic [3:0] w_win_inc;
    logic       w_classify;
    logic       w_is_inc;
    logic       w_is_hold;
    logic       w_wrap;
    logic       w_jump;
    logic       w_match;
    logic [1:0] w_state_nxt;
    logic [3:0] w_win_nxt;

    assign w_exp      = r_prev_count + 4'd1;
    assign w_win_inc  = r_win_wraps + 4'd1;
    assign w_classify = i_en & r_prev_valid;
    assign w_is_inc   = (i_count == w_exp);
    assign w_is_hold  = (i_count == r_prev_count);
    assign w_wrap     = w_classify & w_is_inc & (r_prev_count == 4'hF);
    assign w_jump     = w_classify & ~w_is_inc & ~w_is_hold;
    // A hold at the compare value must not re-fire, so suppress when the
    // previous valid sample already matched.
    assign w_match    = i_en & (i_count == i_cmp_val)
                        & ~(r_prev_valid & (r_prev_count == i_cmp_val));

    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win_wraps;
        if (!i_en) begin
            w_state_nxt = ST_IDLE;
            w_win_nxt   = 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_ARMED;
                    w_win_nxt   = 4'd0;
                end
                ST_ARMED: begin
                    // Jump wins over an alarm reached in the same cycle.
                    if (w_jump) begin
                        w_state_nxt = ST_FAULT;
                    end else if (w_wrap) begin
                        w_win_nxt = w_win_inc;
                        if (w_win_inc == ALARM_LVL) begin
                            w_state_nxt = ST_ALARM;
                        end
                    end
                end
                default: begin
                    // ALARM / FAULT: held until acknowledged; a wrap on the
                    // ack cycle already counts toward the next window.
                    if (i_irq_ack) begin
                        w_state_nxt = ST_ARMED;
                        w_win_nxt   = {3'b000, w_wrap};
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev_count <= 4'd0;
            r_prev_valid <= 1'b0;
            r_win_wraps  <= 4'd0;
            r_state      <= ST_IDLE;
            r_wrap_cnt   <= '0;
            r_match      <= 1'b0;
            r_jump       <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            if (i_en) begin
                r_prev_count <= i_count;
                r_prev_valid <= 1'b1;
            end else begin
                r_prev_valid <= 1'b0;
            end
            if (w_wrap && !(&r_wrap_cnt)) begin
                r_wrap_cnt <= r_wrap_cnt + WRAP_W'(1);
            end
            r_win_wraps <= w_win_nxt;
            r_state     <= w_state_nxt;
            r_irq       <= (w_state_nxt == ST_ALARM) || (w_state_nxt == ST_FAULT);
            r_match     <= w_match;
            r_jump      <= w_jump;
        end
    end

    assign o_wrap_cnt = r_wrap_cnt;
    assign o_match    = r_match;
    assign o_jump     = r_jump;
    assign o_irq      = r_irq;
    assign o_state    = r_state;

endmodule
